// File: rtl/jelly3_img_bayer_wb_pkg.sv
// Shared types and constants for the Bayer black-level / white-balance stage.
package jelly3_img_bayer_wb_pkg;

    localparam int          DEF_OFFSET_BITS = 10;
    localparam int          DEF_GAIN_BITS   = 12;
    localparam int          GAIN_FRAC_BITS  = 8;
    localparam int unsigned GAIN_ONE        = 32'h100;

    typedef logic [1:0]                 phase_t;
    typedef logic [DEF_OFFSET_BITS-1:0] offset_t;
    typedef logic [DEF_GAIN_BITS-1:0]   gain_t;

    // Bayer index as seen under phase 0.
    typedef enum logic [1:0] {
        BAYER_R  = 2'd0,
        BAYER_GR = 2'd1,
        BAYER_GB = 2'd2,
        BAYER_B  = 2'd3
    } bayer_idx_e;

    // Map row/column parity through the configured phase onto a coefficient index.
    function automatic bayer_idx_e bayer_index(input phase_t phase, input logic row_par, input logic col_par);
        return bayer_idx_e'({row_par ^ phase[1], col_par ^ phase[0]});
    endfunction

endpackage

// File: rtl/jelly3_img_bayer_wb_calc.sv
// Single-tap pipeline: offset subtract with clamp, gain multiply, round and saturate.
module jelly3_img_bayer_wb_calc
    import jelly3_img_bayer_wb_pkg::*;
#(
    parameter int CH_BITS     = 10,
    parameter int OFFSET_BITS = 10,
    parameter int GAIN_BITS   = 12
) (
    input  logic                   aclk_i,
    input  logic                   aresetn_i,
    input  logic                   cke_i,
    input  logic [CH_BITS-1:0]     data_i,
    input  logic [OFFSET_BITS-1:0] offset_i,
    input  logic [GAIN_BITS-1:0]   gain_i,
    output logic [CH_BITS-1:0]     data_o
);

    localparam int DIFF_BITS = ((CH_BITS > OFFSET_BITS) ? CH_BITS : OFFSET_BITS) + 1;
    localparam int PROD_BITS = CH_BITS + GAIN_BITS;
    localparam int SUM_BITS  = PROD_BITS + 1;
    localparam logic [SUM_BITS-1:0] ROUND_HALF = SUM_BITS'(1) << (GAIN_FRAC_BITS - 1);
    localparam logic [SUM_BITS-1:0] SAT_MAX    = (SUM_BITS'(1) << CH_BITS) - SUM_BITS'(1);

    logic [DIFF_BITS-1:0] diff;
    logic [SUM_BITS-1:0]  scaled;
    logic [CH_BITS-1:0]   diff_d, diff_q;
    logic [GAIN_BITS-1:0] gain_q;
    logic [PROD_BITS-1:0] prod_d, prod_q;
    logic [CH_BITS-1:0]   res_d, res_q;

    // Next-state values of the three stages; the extra diff bit flags a negative result.
    always_comb begin
        diff   = DIFF_BITS'(data_i) - DIFF_BITS'(offset_i);
        diff_d = diff[DIFF_BITS-1] ? '0 : diff[CH_BITS-1:0];
        prod_d = PROD_BITS'(diff_q) * PROD_BITS'(gain_q);
        scaled = (SUM_BITS'(prod_q) + ROUND_HALF) >> GAIN_FRAC_BITS;
        res_d  = (scaled > SAT_MAX) ? SAT_MAX[CH_BITS-1:0] : scaled[CH_BITS-1:0];
    end

    // Stage registers; the gain travels with the sample so stage 2 never sees a newer set.
    always_ff @(posedge aclk_i) begin
        if (!aresetn_i) begin
            diff_q <= '0;
            gain_q <= '0;
            prod_q <= '0;
            res_q  <= '0;
        end else if (cke_i) begin
            // NOTE: non-blocking assignments make every stage sample the previous stage's old value.
            diff_q <= diff_d;
            gain_q <= gain_i;
            prod_q <= prod_d;
            res_q  <= res_d;
        end
    end

    assign data_o = res_q;

endmodule

// File: rtl/jelly3_img_bayer_wb.sv
// Bayer black-level and white-balance stage with frame-synchronous parameter loading.
module jelly3_img_bayer_wb
    import jelly3_img_bayer_wb_pkg::*;
#(
    parameter int     TAPS        = 4,      // must be even: column parity is then tap index parity
    parameter int     CH_BITS     = 10,
    parameter int     OFFSET_BITS = 10,
    parameter int     GAIN_BITS   = 12,
    parameter phase_t INIT_PHASE  = 2'b00
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       cke,

    input  logic [1:0]                 param_phase,
    input  logic [4*OFFSET_BITS-1:0]   param_offset,
    input  logic [4*GAIN_BITS-1:0]     param_gain,
    input  logic                       in_update_req,
    output logic                       out_update_ack,

    input  logic                       s_row_first,
    input  logic                       s_row_last,
    input  logic                       s_col_first,
    input  logic                       s_col_last,
    input  logic [TAPS-1:0]            s_de,
    input  logic [TAPS*CH_BITS-1:0]    s_data,
    input  logic                       s_valid,

    output logic                       m_row_first,
    output logic                       m_row_last,
    output logic                       m_col_first,
    output logic                       m_col_last,
    output logic [TAPS-1:0]            m_de,
    output logic [TAPS*CH_BITS-1:0]    m_data,
    output logic                       m_valid
);

    localparam int SB_BITS     = TAPS + 5;
    localparam int PIPE_STAGES = 3;

    logic beat_start;
    logic load;

    assign beat_start = s_valid & s_row_first & s_col_first;
    assign load       = beat_start & in_update_req;

    phase_t                   phase_q, phase_d;
    logic [4*OFFSET_BITS-1:0] offset_q, offset_d;
    logic [4*GAIN_BITS-1:0]   gain_q, gain_d;
    logic                     ack_d, ack_q;

    // Parameter set seen by the current beat; a loading frame start already uses the new set.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        phase_d  = phase_q;
        offset_d = offset_q;
        gain_d   = gain_q;
        ack_d    = load;
        if (load) begin
            phase_d  = param_phase;
            offset_d = param_offset;
            gain_d   = param_gain;
        end
    end

    // Active parameter set and acknowledge pulse.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            phase_q  <= INIT_PHASE;
            offset_q <= '0;
            gain_q   <= {4{GAIN_BITS'(GAIN_ONE)}};
            ack_q    <= 1'b0;
        end else if (cke) begin
            phase_q  <= phase_d;
            offset_q <= offset_d;
            gain_q   <= gain_d;
            ack_q    <= ack_d;
        end
    end

    assign out_update_ack = ack_q;

    logic row_cur;
    logic row_par_d, row_par_q;
    logic first_d, first_q;

    // Row parity of the incoming beat; the first beat after reset counts as row 0.
    always_comb begin
        row_par_d = row_par_q;
        first_d   = first_q;
        if (beat_start || first_q) begin
            row_cur = 1'b0;
        end else if (s_col_first) begin
            row_cur = ~row_par_q;
        end else begin
            row_cur = row_par_q;
        end
        if (s_valid) begin
            row_par_d = row_cur;
            first_d   = 1'b0;
        end
    end

    // Row parity tracking register.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            row_par_q <= 1'b0;
            first_q   <= 1'b1;
        end else if (cke) begin
            row_par_q <= row_par_d;
            first_q   <= first_d;
        end
    end

    logic [OFFSET_BITS-1:0] offset_arr [4];
    logic [GAIN_BITS-1:0]   gain_arr   [4];

    // Unpack the coefficient vectors for index lookup.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            offset_arr[k] = offset_d[k*OFFSET_BITS +: OFFSET_BITS];
            gain_arr[k]   = gain_d[k*GAIN_BITS +: GAIN_BITS];
        end
    end

    for (genvar t = 0; t < TAPS; t++) begin : g_tap
        bayer_idx_e tap_idx;

        assign tap_idx = bayer_index(phase_d, row_cur, 1'(t % 2));

        jelly3_img_bayer_wb_calc #(
            .CH_BITS     (CH_BITS),
            .OFFSET_BITS (OFFSET_BITS),
            .GAIN_BITS   (GAIN_BITS)
        ) u_calc (
            .aclk_i    (aclk),
            .aresetn_i (aresetn),
            .cke_i     (cke),
            .data_i    (s_data[t*CH_BITS +: CH_BITS]),
            .offset_i  (offset_arr[tap_idx]),
            .gain_i    (gain_arr[tap_idx]),
            .data_o    (m_data[t*CH_BITS +: CH_BITS])
        );
    end

    logic [SB_BITS-1:0] sb_q [PIPE_STAGES];

    // Sideband delay line matching the datapath latency.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            // NOTE: this small delay line is reset so in-flight beats vanish and m_valid drops at once.
            for (int i = 0; i < PIPE_STAGES; i++) begin
                sb_q[i] <= '0;
            end
        end else if (cke) begin
            sb_q[0] <= {s_valid, s_row_first, s_row_last, s_col_first, s_col_last, s_de};
            for (int i = 1; i < PIPE_STAGES; i++) begin
                sb_q[i] <= sb_q[i-1];
            end
        end
    end

    assign {m_valid, m_row_first, m_row_last, m_col_first, m_col_last, m_de} = sb_q[PIPE_STAGES-1];

endmodule

// File: tb/tb_jelly3_img_bayer_wb.sv
// Directed self-checking bench for jelly3_img_bayer_wb (TAPS=4, 10-bit samples).
module tb_jelly3_img_bayer_wb;

    localparam int TAPS = 4;
    localparam int CH   = 10;
    localparam int OB   = 10;
    localparam int GB   = 12;

    logic                aclk = 1'b0;
    logic                aresetn = 1'b0;
    logic                cke = 1'b0;
    logic [1:0]          param_phase = '0;
    logic [4*OB-1:0]     param_offset = '0;
    logic [4*GB-1:0]     param_gain = '0;
    logic                in_update_req = 1'b0;
    logic                out_update_ack;
    logic                s_row_first = 1'b0, s_row_last = 1'b0, s_col_first = 1'b0, s_col_last = 1'b0;
    logic [TAPS-1:0]     s_de = '0;
    logic [TAPS*CH-1:0]  s_data = '0;
    logic                s_valid = 1'b0;
    logic                m_row_first, m_row_last, m_col_first, m_col_last;
    logic [TAPS-1:0]     m_de;
    logic [TAPS*CH-1:0]  m_data;
    logic                m_valid;

    always #5 aclk = ~aclk;

    jelly3_img_bayer_wb #(
        .TAPS(TAPS), .CH_BITS(CH), .OFFSET_BITS(OB), .GAIN_BITS(GB), .INIT_PHASE(2'b00)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .cke(cke),
        .param_phase(param_phase), .param_offset(param_offset), .param_gain(param_gain),
        .in_update_req(in_update_req), .out_update_ack(out_update_ack),
        .s_row_first(s_row_first), .s_row_last(s_row_last),
        .s_col_first(s_col_first), .s_col_last(s_col_last),
        .s_de(s_de), .s_data(s_data), .s_valid(s_valid),
        .m_row_first(m_row_first), .m_row_last(m_row_last),
        .m_col_first(m_col_first), .m_col_last(m_col_last),
        .m_de(m_de), .m_data(m_data), .m_valid(m_valid)
    );

    typedef struct packed {
        logic              rf;
        logic              rl;
        logic              cf;
        logic              cl;
        logic [TAPS-1:0]   de;
        logic [TAPS*CH-1:0] data;
    } beat_t;

    beat_t out_q[$];
    int    ack_cnt = 0;
    int    tests = 0;
    int    fails = 0;
    bit    rnd_cke = 1'b0;

    function automatic beat_t mk(input int rf, input int rl, input int cf, input int cl, input int de,
                                 input int p0, input int p1, input int p2, input int p3);
        beat_t b;
        b.rf   = 1'(rf);
        b.rl   = 1'(rl);
        b.cf   = 1'(cf);
        b.cl   = 1'(cl);
        b.de   = TAPS'(de);
        b.data = {CH'(p3), CH'(p2), CH'(p1), CH'(p0)};
        return b;
    endfunction

    function automatic beat_t observe();
        beat_t b;
        b.rf   = m_row_first;
        b.rl   = m_row_last;
        b.cf   = m_col_first;
        b.cl   = m_col_last;
        b.de   = m_de;
        b.data = m_data;
        return b;
    endfunction

    // Output collector: records each valid beat and each ack after an enabled clock edge.
    always @(posedge aclk) begin : monitor
        logic en;
        en = cke && aresetn;
        #1;
        if (en && m_valid) out_q.push_back(observe());
        if (en && out_update_ack) ack_cnt++;
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic set_params(input logic [1:0] ph, input logic [4*OB-1:0] off, input logic [4*GB-1:0] g);
        param_phase  = ph;
        param_offset = off;
        param_gain   = g;
    endtask

    // Present one beat, held until an enabled edge accepts it; entered and left at a negedge.
    task automatic send(input beat_t b, input logic req);
        bit done = 1'b0;
        int tries = 0;
        s_row_first   = b.rf;
        s_row_last    = b.rl;
        s_col_first   = b.cf;
        s_col_last    = b.cl;
        s_de          = b.de;
        s_data        = b.data;
        s_valid       = 1'b1;
        in_update_req = req;
        while (!done) begin
            cke = (rnd_cke && tries < 8) ? 1'($urandom_range(0, 1)) : 1'b1;
            tries++;
            @(posedge aclk);
            done = cke;
            @(negedge aclk);
        end
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        cke     = 1'b1;
        repeat (n) @(negedge aclk);
    endtask

    task automatic test_reset();
        cke = 1'b1;
        s_valid = 1'b1; s_row_first = 1'b1; s_col_first = 1'b1; in_update_req = 1'b1;
        s_data = '1; s_de = '1;
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b expected 0", m_valid); end
        tests++; if (m_de !== '0) begin fails++; $display("FAIL reset_de got %h expected 0", m_de); end
        tests++;
        if ({m_row_first, m_row_last, m_col_first, m_col_last} !== 4'b0000) begin
            fails++; $display("FAIL reset_markers got %b expected 0000", {m_row_first, m_row_last, m_col_first, m_col_last});
        end
        tests++; if (m_data !== '0) begin fails++; $display("FAIL reset_data got %h expected 0", m_data); end
        tests++; if (out_update_ack !== 1'b0) begin fails++; $display("FAIL reset_ack got %b expected 0", out_update_ack); end
        s_valid = 1'b0; in_update_req = 1'b0; s_row_first = 1'b0; s_col_first = 1'b0;
        aresetn = 1'b1;
        @(negedge aclk);
    endtask

    // One beat through the reset-default (identity) set: visible in the third cycle only.
    task automatic test_latency();
        beat_t exp_b;
        exp_b = mk(1, 1, 1, 1, 15, 11, 22, 33, 44);
        out_q.delete();
        s_row_first = 1'b1; s_row_last = 1'b1; s_col_first = 1'b1; s_col_last = 1'b1;
        s_de = 4'hF; s_data = exp_b.data; s_valid = 1'b1; in_update_req = 1'b0; cke = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        s_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tests++;
            if (m_valid !== (c == 3)) begin fails++; $display("FAIL latency_valid_c%0d got %b expected %b", c, m_valid, (c == 3)); end
            if (c == 3) begin
                tests++;
                if (observe() !== exp_b) begin fails++; $display("FAIL latency_beat got %h expected %h", observe(), exp_b); end
            end
            @(negedge aclk);
        end
        idle(4);
        out_q.delete();
    endtask

    // 320x240 ramp through the identity set: output equals input, markers aligned.
    task automatic test_identity_ramp();
        int    bad = 0;
        int    first_bad = -1;
        int    n = 0;
        beat_t e;
        beat_t got_first = '0;
        beat_t exp_first = '0;
        rnd_cke = 1'b0;
        out_q.delete();
        for (int r = 0; r < 240; r++) begin
            for (int b = 0; b < 80; b++) begin
                send(mk(r == 0, r == 239, b == 0, b == 79, (r + b) % 16,
                        (r*320 + b*4) % 1024, (r*320 + b*4 + 1) % 1024,
                        (r*320 + b*4 + 2) % 1024, (r*320 + b*4 + 3) % 1024), 1'b0);
            end
        end
        idle(6);
        tests++;
        if (out_q.size() !== 19200) begin fails++; $display("FAIL ramp_count got %0d expected 19200", out_q.size()); end
        for (int r = 0; r < 240; r++) begin
            for (int b = 0; b < 80; b++) begin
                e = mk(r == 0, r == 239, b == 0, b == 79, (r + b) % 16,
                       (r*320 + b*4) % 1024, (r*320 + b*4 + 1) % 1024,
                       (r*320 + b*4 + 2) % 1024, (r*320 + b*4 + 3) % 1024);
                if (n < out_q.size() && out_q[n] !== e) begin
                    bad++;
                    if (first_bad < 0) begin first_bad = n; got_first = out_q[n]; exp_first = e; end
                end
                n++;
            end
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL ramp_beats %0d beats differ, first at %0d got %h expected %h", bad, first_bad, got_first, exp_first);
        end
        out_q.delete();
    endtask

    task automatic test_offset();
        beat_t exp_b [2];
        set_params(2'b00, {10'd0, 10'd0, 10'd0, 10'd64}, {4{12'h100}});
        out_q.delete(); ack_cnt = 0;
        send(mk(1, 0, 1, 1, 15, 40, 77, 100, 5), 1'b1);
        send(mk(0, 1, 1, 1, 15, 64, 64, 64, 64), 1'b0);
        idle(6);
        exp_b[0] = mk(1, 0, 1, 1, 15, 0, 77, 36, 5);
        exp_b[1] = mk(0, 1, 1, 1, 15, 64, 64, 64, 64);
        tests++; if (out_q.size() !== 2) begin fails++; $display("FAIL offset_count got %0d expected 2", out_q.size()); end
        for (int i = 0; i < 2 && i < out_q.size(); i++) begin
            tests++;
            if (out_q[i] !== exp_b[i]) begin fails++; $display("FAIL offset_beat%0d got %h expected %h", i, out_q[i], exp_b[i]); end
        end
        tests++; if (ack_cnt !== 1) begin fails++; $display("FAIL offset_ack got %0d expected 1", ack_cnt); end
    endtask

    task automatic test_gain();
        beat_t exp_b [2];
        set_params(2'b00, '0, {12'h200, 12'h100, 12'h180, 12'h100});
        out_q.delete();
        send(mk(1, 0, 1, 1, 15, 7, 3, 1023, 1000), 1'b1);
        send(mk(0, 1, 1, 1, 6, 9, 600, 0, 300), 1'b0);
        idle(6);
        exp_b[0] = mk(1, 0, 1, 1, 15, 7, 5, 1023, 1023);
        exp_b[1] = mk(0, 1, 1, 1, 6, 9, 1023, 0, 600);
        tests++; if (out_q.size() !== 2) begin fails++; $display("FAIL gain_count got %0d expected 2", out_q.size()); end
        for (int i = 0; i < 2 && i < out_q.size(); i++) begin
            tests++;
            if (out_q[i] !== exp_b[i]) begin fails++; $display("FAIL gain_beat%0d got %h expected %h", i, out_q[i], exp_b[i]); end
        end
    endtask

    task automatic test_phase();
        beat_t exp_b [4];
        set_params(2'b11, {10'd10, 10'd0, 10'd0, 10'd0}, {4{12'h100}});
        out_q.delete();
        send(mk(1, 0, 1, 0, 15, 50, 50, 5, 20), 1'b1);
        send(mk(1, 0, 0, 1, 15, 50, 50, 50, 50), 1'b0);
        send(mk(0, 1, 1, 0, 15, 50, 50, 50, 50), 1'b0);
        send(mk(0, 1, 0, 1, 15, 50, 50, 50, 50), 1'b0);
        idle(6);
        exp_b[0] = mk(1, 0, 1, 0, 15, 40, 50, 0, 20);
        exp_b[1] = mk(1, 0, 0, 1, 15, 40, 50, 40, 50);
        exp_b[2] = mk(0, 1, 1, 0, 15, 50, 50, 50, 50);
        exp_b[3] = mk(0, 1, 0, 1, 15, 50, 50, 50, 50);
        tests++; if (out_q.size() !== 4) begin fails++; $display("FAIL phase_count got %0d expected 4", out_q.size()); end
        for (int i = 0; i < 4 && i < out_q.size(); i++) begin
            tests++;
            if (out_q[i] !== exp_b[i]) begin fails++; $display("FAIL phase_beat%0d got %h expected %h", i, out_q[i], exp_b[i]); end
        end
    endtask

    // Request raised mid-frame must wait for the next frame start; one ack only.
    task automatic test_update_midframe(input bit rnd);
        beat_t exp_b [4];
        rnd_cke = rnd;
        set_params(2'b11, {10'd10, 10'd0, 10'd0, 10'd0}, {4{12'h100}});
        send(mk(1, 1, 1, 1, 15, 0, 0, 0, 0), 1'b1);
        idle(6);
        out_q.delete(); ack_cnt = 0;
        set_params(2'b00, '0, {4{12'h200}});
        send(mk(1, 0, 1, 1, 15, 100, 100, 100, 100), 1'b0);
        send(mk(0, 1, 1, 1, 15, 100, 100, 100, 100), 1'b1);
        send(mk(1, 0, 1, 1, 15, 100, 100, 100, 100), 1'b1);
        send(mk(0, 1, 1, 1, 15, 100, 100, 100, 100), 1'b1);
        in_update_req = 1'b0;
        idle(8);
        exp_b[0] = mk(1, 0, 1, 1, 15, 90, 100, 90, 100);
        exp_b[1] = mk(0, 1, 1, 1, 15, 100, 100, 100, 100);
        exp_b[2] = mk(1, 0, 1, 1, 15, 200, 200, 200, 200);
        exp_b[3] = mk(0, 1, 1, 1, 15, 200, 200, 200, 200);
        tests++; if (out_q.size() !== 4) begin fails++; $display("FAIL update_r%0d_count got %0d expected 4", rnd, out_q.size()); end
        for (int i = 0; i < 4 && i < out_q.size(); i++) begin
            tests++;
            if (out_q[i] !== exp_b[i]) begin fails++; $display("FAIL update_r%0d_beat%0d got %h expected %h", rnd, i, out_q[i], exp_b[i]); end
        end
        tests++; if (ack_cnt !== 1) begin fails++; $display("FAIL update_r%0d_ack got %0d expected 1", rnd, ack_cnt); end
        rnd_cke = 1'b0;
    endtask

    // Reset mid-frame: in-flight beats vanish, the set returns to identity, new beats flow after 3 cycles.
    task automatic test_reset_midframe();
        beat_t exp_b [2];
        rnd_cke = 1'b0;
        out_q.delete();
        send(mk(1, 0, 1, 0, 15, 1, 2, 3, 4), 1'b0);
        send(mk(1, 0, 0, 1, 15, 5, 6, 7, 8), 1'b0);
        aresetn = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        exp_b[0] = mk(0, 0, 1, 0, 15, 10, 20, 30, 40);
        exp_b[1] = mk(0, 0, 0, 1, 9, 50, 60, 70, 80);
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid_c0 got %b expected 0", m_valid); end
        send(exp_b[0], 1'b0);
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid_c1 got %b expected 0", m_valid); end
        send(exp_b[1], 1'b0);
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid_c2 got %b expected 0", m_valid); end
        idle(6);
        tests++; if (out_q.size() !== 2) begin fails++; $display("FAIL rstmid_count got %0d expected 2", out_q.size()); end
        for (int i = 0; i < 2 && i < out_q.size(); i++) begin
            tests++;
            if (out_q[i] !== exp_b[i]) begin fails++; $display("FAIL rstmid_beat%0d got %h expected %h", i, out_q[i], exp_b[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_identity_ramp();
        test_offset();
        test_gain();
        test_phase();
        test_update_midframe(1'b0);
        test_update_midframe(1'b1);
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
